fifo_p2s_serializer: RTL and testbench

//  Downstream consumer of the parameterised loop FIFO (fixed read latency NUM_LOOPS).

---
 rtl/fifo_p2s_serializer_pkg.sv | 17 +
 rtl/fifo_p2s_serializer_hold_buffer.sv | 59 +++++
 rtl/fifo_p2s_serializer.sv | 112 +++++++++++
 tb/tb_fifo_p2s_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_p2s_serializer_pkg.sv
// Shared types and width helpers for the FIFO-to-serial converter.
package p2s_pkg;

    typedef enum logic {
        P2S_IDLE  = 1'b0,
        P2S_SHIFT = 1'b1
    } p2s_state_t;

    function automatic int cnt_w(input int fifo_width);
        return (fifo_width > 1) ? $clog2(fifo_width) : 1;
    endfunction

    function automatic int crd_w(input int num_loops);
        return $clog2(num_loops + 2);
    endfunction

endpackage

// File: rtl/fifo_p2s_serializer_hold_buffer.sv
// Small synchronous FIFO that absorbs words returning from the upstream read pipeline.
module p2s_hold_buffer #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fifo_p2s_serializer.sv
// Pops an upstream fixed-latency FIFO under credit control and serialises each word
// onto a 1-bit valid/ready stream with start/end-of-word markers.
module fifo_p2s_serializer
    import p2s_pkg::*;
#(
    parameter int FIFO_WIDTH = 11,
    parameter int NUM_LOOPS  = 3,
    parameter int MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    output logic                  pop,
    input  logic [FIFO_WIDTH-1:0] pop_data,
    input  logic                  ser_ready,
    output logic                  ser_valid,
    output logic                  ser_data,
    output logic                  ser_sof,
    output logic                  ser_eof,
    output logic                  busy
);

    localparam int CNT_W      = cnt_w(FIFO_WIDTH);
    localparam int CRD_W      = crd_w(NUM_LOOPS);
    localparam int HOLD_DEPTH = NUM_LOOPS + 1;

    logic [NUM_LOOPS-1:0]  pop_dly;
    logic [CRD_W-1:0]      credits;
    p2s_state_t            state;
    logic [FIFO_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

    logic                  capture;
    logic                  load;
    logic                  ser_beat;
    logic                  last_beat;
    logic [FIFO_WIDTH-1:0] hb_rd_data;
    logic                  hb_empty;
    logic                  hb_full;

    assign capture   = pop_dly[NUM_LOOPS-1];
    assign ser_beat  = (state == P2S_SHIFT) && ser_ready;
    assign last_beat = ser_beat && (bit_cnt == CNT_W'(FIFO_WIDTH - 1));
    assign load      = !hb_empty && ((state == P2S_IDLE) || last_beat);
    // Popping during reset would lose the word, since the delay line is being cleared.
    assign pop       = !rst && !empty && (credits != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_dly <= '0;
        end else begin
            pop_dly[0] <= pop;
            for (int unsigned i = 1; i < NUM_LOOPS; i++) begin
                pop_dly[i] <= pop_dly[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CRD_W'(NUM_LOOPS + 1);
        end else begin
            case ({pop, load})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    p2s_hold_buffer #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (HOLD_DEPTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (pop_data),
        .rd_en   (load),
        .rd_data (hb_rd_data),
        .empty   (hb_empty),
        .full    (hb_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= P2S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            state   <= P2S_SHIFT;
            shreg   <= hb_rd_data;
            bit_cnt <= '0;
        end else if (last_beat) begin
            state   <= P2S_IDLE;
        end else if (ser_beat) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= (MSB_FIRST != 0) ? {shreg[FIFO_WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg[FIFO_WIDTH-1:1]};
        end
    end

    assign ser_valid = (state == P2S_SHIFT);
    assign ser_data  = ser_valid && ((MSB_FIRST != 0) ? shreg[FIFO_WIDTH-1] : shreg[0]);
    assign ser_sof   = ser_valid && (bit_cnt == '0);
    assign ser_eof   = ser_valid && (bit_cnt == CNT_W'(FIFO_WIDTH - 1));
    assign busy      = (|pop_dly) || !hb_empty || (state == P2S_SHIFT);

    hold_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && hb_full && !load));

endmodule

// File: tb/tb_fifo_p2s_serializer.sv
// Scoreboard bench: an upstream FIFO model feeds two serialisers (MSB-first and LSB-first)
// and a monitor checks every accepted bit against the pushed word sequence.
module tb_fifo_p2s_serializer;

    localparam int W  = 11;
    localparam int NL = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         empty;
    logic [W-1:0] pop_data;
    logic         ser_ready;
    logic         pop0, v0, d0, s0, e0, b0;
    logic         pop1, v1, d1, s1, e1, b1;

    always #5 clk = ~clk;

    fifo_p2s_serializer #(.FIFO_WIDTH(W), .NUM_LOOPS(NL), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .empty(empty), .pop(pop0), .pop_data(pop_data),
        .ser_ready(ser_ready), .ser_valid(v0), .ser_data(d0), .ser_sof(s0),
        .ser_eof(e0), .busy(b0)
    );

    fifo_p2s_serializer #(.FIFO_WIDTH(W), .NUM_LOOPS(NL), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .empty(empty), .pop(pop1), .pop_data(pop_data),
        .ser_ready(ser_ready), .ser_valid(v1), .ser_data(d1), .ser_sof(s1),
        .ser_eof(e1), .busy(b1)
    );

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] up_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] slot[8];
    bit           slot_v[8];
    bit           pop_log[$];
    bit           rand_ready = 1'b0;
    int           pop_cnt = 0;
    int           bidx = 0;
    int           vcount = 0;
    int           first_v = -1;
    int           last_v = -1;
    logic [63:0]  obs0 = '0;
    logic [63:0]  obs1 = '0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Upstream FIFO model: words leave on pop and reappear on pop_data NL cycles later.
    task automatic tick();
        bit           p;
        logic [W-1:0] w;
        @(negedge clk);
        p = pop0;
        if (p && empty) chk("pop_while_empty", 1, 0);
        pop_log.push_back(p);
        if (p) pop_cnt++;
        @(posedge clk);
        #1;
        if (p && up_q.size() > 0) begin
            w = up_q.pop_front();
            slot[(cyc + NL) % 8]   = w;
            slot_v[(cyc + NL) % 8] = 1'b1;
        end
        slot_v[cyc % 8] = 1'b0;
        cyc++;
        pop_data = slot_v[cyc % 8] ? slot[cyc % 8] : W'($urandom);
        empty = (up_q.size() == 0);
        if (rand_ready) ser_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [W-1:0] w);
        up_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !b0) break;
            tick();
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: compares each accepted beat of both instances with the scoreboard head word.
    initial begin
        bit           pv, pr, pd0, pd1, ps, pe;
        logic [W-1:0] w;
        pv = 1'b0; pr = 1'b0; pd0 = 1'b0; pd1 = 1'b0; ps = 1'b0; pe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                bidx = 0;
            end else begin
                chk("pop_match", int'(pop1), int'(pop0));
                chk("valid_match", int'(v1), int'(v0));
                if (pv && !pr) begin
                    chk("stall_hold", int'({v0, d0, d1, s0, e0}), int'({1'b1, pd0, pd1, ps, pe}));
                end
                if (v0) begin
                    vcount++;
                    if (first_v < 0) first_v = cyc;
                    last_v = cyc;
                end
                if (v0 && ser_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        w = exp_q[0];
                        chk("bit_msb", int'(d0), int'(w[W-1-bidx]));
                        chk("bit_lsb", int'(d1), int'(w[bidx]));
                        chk("sof", int'({s0, s1}), (bidx == 0) ? 3 : 0);
                        chk("eof", int'({e0, e1}), (bidx == W - 1) ? 3 : 0);
                        obs0 = {obs0[62:0], d0};
                        obs1 = {obs1[62:0], d1};
                        bidx++;
                        if (bidx == W) begin
                            void'(exp_q.pop_front());
                            bidx = 0;
                        end
                    end
                end
                pv = v0; pr = ser_ready; pd0 = d0; pd1 = d1; ps = s0; pe = e0;
            end
        end
    end

    initial begin
        int c0, i0, run;
        rst = 1'b1; empty = 1'b1; ser_ready = 1'b0; pop_data = '0;
        repeat (3) tick();
        chk("reset_outputs", int'({pop0, v0, d0, s0, e0, b0}), 0);
        chk("reset_outputs_lsb", int'({pop1, v1, d1, s1, e1, b1}), 0);
        rst = 1'b0;
        tick();

        // Single word, latency from pop to first serial bit
        ser_ready = 1'b1;
        obs0 = '0; obs1 = '0; first_v = -1;
        c0 = cyc;
        push(11'h5A3);
        wait_drain("t1_drain", 60);
        chk("t1_first_bit_cycle", first_v, c0 + 5);
        chk("t1_bits_msb", int'(obs0[10:0]), int'(11'b10110100011));
        chk("t1_bits_lsb", int'(obs1[10:0]), int'(11'b11000101101));

        // Back-to-back words, no bubble between them
        first_v = -1; vcount = 0;
        for (int k = 1; k <= 4; k++) push(W'(k));
        wait_drain("t2_drain", 100);
        chk("t2_valid_cycles", vcount, 4 * W);
        chk("t2_valid_span", last_v - first_v + 1, 4 * W);

        // Empty upstream FIFO
        pop_cnt = 0; vcount = 0;
        repeat (20) tick();
        chk("t6_pops", pop_cnt, 0);
        chk("t6_valid", vcount, 0);

        // Reset in the middle of a word
        push(W'($urandom));
        for (int i = 0; i < 60 && !(bidx == 4 && v0); i++) tick();
        chk("t5_reached_bit5", bidx, 4);
        rst = 1'b1; ser_ready = 1'b0;
        exp_q.delete();
        tick();
        chk("t5_after_reset", int'({v0, pop0, b0, s0, e0}), 0);
        rst = 1'b0;

        // Full backpressure: 4 credits drain at once, one more after the shifter loads
        pop_log.delete(); pop_cnt = 0;
        for (int k = 0; k < 8; k++) push(W'($urandom));
        repeat (30) tick();
        i0 = -1;
        foreach (pop_log[k]) if (i0 < 0 && pop_log[k]) i0 = k;
        run = 0;
        if (i0 >= 0) while (i0 + run < pop_log.size() && pop_log[i0 + run]) run++;
        chk("t3_first_pop_burst", run, NL + 1);
        chk("t3_total_pops", pop_cnt, NL + 2);
        chk("t3_left_upstream", up_q.size(), 8 - (NL + 2));
        chk("t3_stalled_valid", int'(v0), 1);
        ser_ready = 1'b1;
        wait_drain("t3_drain", 300);

        // Random backpressure and random arrival gaps
        rand_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            push(W'($urandom));
            repeat ($urandom_range(0, 6)) tick();
        end
        wait_drain("t4_drain", 3000);
        rand_ready = 1'b0;
        ser_ready = 1'b1;
        tick();
        chk("final_idle", int'({b0, b1, v0}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
